hamming74_deframer: RTL and testbench
=====================================

Name: hamming74_deframer

Overview:
- Receive-path stage directly upstream of the 24-bit nibble unbuffer.
- Accepts a serial bitstream from the demodulator, one bit per cycle when valid, and frames it into 7-bit Hamming(7,4) codewords.
- Corrects single-bit errors, collects 6 decoded nibbles per word, then drives the nibble unbuffer with its required 6-cycle burst and enable protocol.

Parameters:
- NIBBLES, 6: decoded nibbles per word (24-bit word); fixed-size burst.
- ERR_W, 16: width of the corrected-error counter (optional feature only).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is valid this cycle; at most one bit per cycle.
- sync_in  in  1  qualified by bit_valid; marks this bit as the first bit of a new frame.
- nibble_out  out  4  nibble presented to the unbuffer.
- unbuf_en  out  1  unbuffer enable: high while idle, low for exactly 6 burst cycles.
- corr_flag  out  1  one-cycle pulse; the codeword just decoded had a corrected bit.
- err_count  out  ERR_W  saturating count of corrected codewords (see Optional Feature).

Behaviour:
- Reset values (async, reset=0):
  - nibble_out=0, unbuf_en=1, corr_flag=0, err_count=0
  - bit count=0, nibble count=0, state IDLE
- Codeword format: positions 1..7 = p1 p2 d1 p3 d2 d3 d4, position 1 received first.
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
- Decode:
  - Syndrome s = {s3,s2,s1}, where s1=p1^d1^d2^d4, s2=p2^d1^d3^d4, s3=p3^d2^d3^d4.
  - If s≠0, invert position s.
  - Nibble = {d1,d2,d3,d4}, with d1 as MSB.
  - corr_flag pulses the cycle after the 7th bit is accepted iff s≠0.
- Framing:
  - A 3-bit counter advances on each bit_valid.
  - On the 7th bit, the decoded nibble is written to collect slot [5 - nibble count] and the nibble count increments.
  - sync_in with bit_valid clears the partial codeword and nibble count. That bit becomes bit 1 of codeword 0.
  - A burst in progress is not affected by sync_in.
- bit_valid low: counters and shift register hold.
- States:
  - COLLECT: default after reset.
  - On the 6th nibble, collect slots 5..0 are copied to burst registers, nibble count returns to 0, and the state moves to BURST.
  - BURST: runs 6 cycles, then returns to COLLECT.
- Burst timing, where the 7th bit of codeword 5 is accepted at edge N:
  - Cycles N+1..N+6: unbuf_en=0, nibble_out = slot 5, 4, 3, 2, 1, 0 in turn. Slot 5 is codeword 0 and lands in word bits [23:20].
  - Cycle N+7: unbuf_en=1, nibble_out holds slot 0.
  - The unbuffer word is updated at edge N+8.
- Overlap:
  - A codeword needs at least 7 cycles, so the next frame's first nibble cannot complete before the burst ends.
  - Collection continues during BURST into the collect slots. The burst registers are separate.
- Idle: unbuf_en stays 1 and nibble_out holds its last value. unbuf_en must never drop outside a burst.
- Reset mid-burst: the burst is aborted and outputs return to reset values immediately.

Optional Feature:
- Macro: HAMMING_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 on each corr_flag pulse.
  - It saturates at 2^ERR_W-1 and clears only on reset.
- Undefined:
  - No counter logic; err_count is tied to 0.
  - corr_flag is still produced.

Decomposition:
- Shared package (comm_pkg) holds:
  - the codeword width 7 and nibble width 4
  - the NIBBLES default
  - the state enum COLLECT/BURST
  - syndrome-to-position constants
- One natural sub-module: hamming74_decode.
  - Combinational: 7-bit codeword in; 4-bit nibble and corrected flag out.
  - Shared with the transmit-side encoder's test bench.

Test Plan:
1. Reset mid-burst: assert reset at cycle N+3 → unbuf_en=1 and nibble_out=0 immediately; no further burst cycles.
2. Clean word 0x0F0F0F, bits back-to-back, sync_in on the first bit:
   - Codewords alternate 0000000 / 1111111.
   - Burst on N+1..N+6 is 0,F,0,F,0,F; unbuf_en low exactly 6 cycles.
   - Unbuffer out = 0x0F0F0F.
3. Single-bit error: flip position 3 of codeword 2 in word 0xFFFFFF → nibble 3 still F, one corr_flag pulse; err_count=1 with HAMMING_ERR_CNT_EN.
4. Gapped input: bit_valid low on every other cycle for word 0xA5A5A5 → same burst timing relative to the last bit; output 0xA5A5A5.
5. Resync: sync_in after 20 bits → partial data discarded; the next 42 bits produce exactly one burst with the new word.
6. Saturation (HAMMING_ERR_CNT_EN, ERR_W=2): 5 corrected codewords → err_count=3.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared Hamming(7,4) receive-path definitions: widths, burst length, FSM states
// and syndrome-to-position constants.
package comm_pkg;

   localparam int unsigned CW_W            = 7;
   localparam int unsigned NIB_W           = 4;
   localparam int unsigned NIBBLES_DEFAULT = 6;

   typedef enum logic {
      COLLECT,
      BURST
   } state_t;

   // Syndrome value equals the 1-based codeword position in error.
   localparam logic [2:0] SYN_P1 = 3'd1;
   localparam logic [2:0] SYN_P2 = 3'd2;
   localparam logic [2:0] SYN_D1 = 3'd3;
   localparam logic [2:0] SYN_P3 = 3'd4;
   localparam logic [2:0] SYN_D2 = 3'd5;
   localparam logic [2:0] SYN_D3 = 3'd6;
   localparam logic [2:0] SYN_D4 = 3'd7;

   // Data-bit flip mask {d1,d2,d3,d4}; a parity-position error leaves the data intact.
   function automatic logic [NIB_W-1:0] data_flip(input logic [2:0] syn);
      logic [NIB_W-1:0] mask;
      mask = '0;
      case (syn)
         SYN_D1:                 mask = 4'b1000;
         SYN_D2:                 mask = 4'b0100;
         SYN_D3:                 mask = 4'b0010;
         SYN_D4:                 mask = 4'b0001;
         SYN_P1, SYN_P2, SYN_P3: mask = 4'b0000;
         default:                mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// codeword[6] is position 1 (first received bit), codeword[0] is position 7.
module hamming74_decode
   import comm_pkg::*;
(
   input  logic [CW_W-1:0]  codeword,
   output logic [NIB_W-1:0] nibble_c,
   output logic             corrected_c
);

   logic [2:0] syn;

   always_comb begin
      syn         = '0;
      syn[0]      = codeword[6] ^ codeword[4] ^ codeword[2] ^ codeword[0];
      syn[1]      = codeword[5] ^ codeword[4] ^ codeword[1] ^ codeword[0];
      syn[2]      = codeword[3] ^ codeword[2] ^ codeword[1] ^ codeword[0];
      nibble_c    = {codeword[4], codeword[2], codeword[1], codeword[0]} ^ data_flip(syn);
      corrected_c = (syn != 3'd0);
   end

endmodule

// File: rtl/hamming74_deframer.sv
// Frames a serial bitstream into Hamming(7,4) codewords, corrects them, and bursts
// six nibbles to the unbuffer. HAMMING_ERR_CNT_EN enables the corrected-codeword counter.
module hamming74_deframer
   import comm_pkg::*;
#(
   parameter int unsigned NIBBLES = NIBBLES_DEFAULT,
   parameter int unsigned ERR_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             sync_in,
   output logic [NIB_W-1:0] nibble_out,
   output logic             unbuf_en,
   output logic             corr_flag,
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned BIT_W = $clog2(CW_W);
   localparam int unsigned CNT_W = $clog2(NIBBLES + 1);

   state_t                        state;
   logic [BIT_W-1:0]              bit_cnt;
   logic [CW_W-2:0]               shift;
   logic [CNT_W-1:0]              nib_cnt;
   logic [CNT_W-1:0]              burst_idx;
   logic [NIBBLES-1:0][NIB_W-1:0] slots;
   logic [NIBBLES-1:0][NIB_W-1:0] burst;
   logic [NIB_W-1:0]              dec_nib;
   logic                          dec_corr;
   logic                          cw_done;

   // Decode the six stored bits plus the bit arriving this cycle.
   hamming74_decode u_dec (
      .codeword    ({shift, bit_in}),
      .nibble_c    (dec_nib),
      .corrected_c (dec_corr)
   );

   assign cw_done = bit_valid && !sync_in && (bit_cnt == BIT_W'(CW_W - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= COLLECT;
         bit_cnt    <= '0;
         shift      <= '0;
         nib_cnt    <= '0;
         burst_idx  <= '0;
         slots      <= '0;
         burst      <= '0;
         nibble_out <= '0;
         unbuf_en   <= 1'b1;
         corr_flag  <= 1'b0;
      end else begin
         corr_flag <= 1'b0;

         // Burst runs off its own registers so collection can overlap it.
         if (state == BURST) begin
            if (burst_idx == CNT_W'(NIBBLES)) begin
               unbuf_en <= 1'b1;
               state    <= COLLECT;
            end else begin
               nibble_out <= burst[burst_idx];
               burst_idx  <= burst_idx + CNT_W'(1);
            end
         end

         if (bit_valid) begin
            if (sync_in) begin
               shift   <= (CW_W - 1)'(bit_in);
               bit_cnt <= BIT_W'(1);
               nib_cnt <= '0;
            end else if (cw_done) begin
               bit_cnt        <= '0;
               corr_flag      <= dec_corr;
               slots[nib_cnt] <= dec_nib;
               if (nib_cnt == CNT_W'(NIBBLES - 1)) begin
                  nib_cnt              <= '0;
                  burst                <= slots;
                  burst[NIBBLES-1]     <= dec_nib;
                  nibble_out           <= (NIBBLES == 1) ? dec_nib : slots[0];
                  unbuf_en             <= 1'b0;
                  burst_idx            <= CNT_W'(1);
                  state                <= BURST;
               end else begin
                  nib_cnt <= nib_cnt + CNT_W'(1);
               end
            end else begin
               shift   <= {shift[CW_W-3:0], bit_in};
               bit_cnt <= bit_cnt + BIT_W'(1);
            end
         end
      end
   end

`ifdef HAMMING_ERR_CNT_EN
   logic [ERR_W-1:0] err_q;

   // Saturating count of corrected codewords; cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= '0;
      end else if (corr_flag && (err_q != {ERR_W{1'b1}})) begin
         err_q <= err_q + ERR_W'(1);
      end
   end

   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_hamming74_deframer.sv
// Directed bench for hamming74_deframer: framing, correction, burst timing, resync,
// overlap and mid-burst reset. ERR_W=2 so counter saturation is reachable.
module tb_hamming74_deframer;

`ifdef HAMMING_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       sync_in = 1'b0;
   logic [3:0] nibble_out;
   logic       unbuf_en;
   logic       corr_flag;
   logic [1:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int corr_seen = 0;
   int idle_bad = 0;

   always #5 clk = ~clk;

   hamming74_deframer #(.NIBBLES(6), .ERR_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .sync_in    (sync_in),
      .nibble_out (nibble_out),
      .unbuf_en   (unbuf_en),
      .corr_flag  (corr_flag),
      .err_count  (err_count)
   );

   // Transmit-side encoder: {p1,p2,d1,p3,d2,d3,d4}, position 1 in bit 6.
   function automatic logic [6:0] enc(input logic [3:0] d);
      logic p1, p2, p3;
      p1 = d[3] ^ d[2] ^ d[0];
      p2 = d[3] ^ d[1] ^ d[0];
      p3 = d[2] ^ d[1] ^ d[0];
      return {p1, p2, d[3], p3, d[2], d[1], d[0]};
   endfunction

   task automatic drive(input logic b, input logic v, input logic s, input bit watch);
      @(negedge clk);
      if (watch) begin
         if (unbuf_en !== 1'b1) idle_bad++;
         if (corr_flag === 1'b1) corr_seen++;
      end
      bit_in    = b;
      bit_valid = v;
      sync_in   = s;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      bit_valid = 1'b0;
      sync_in   = 1'b0;
      bit_in    = 1'b0;
      @(negedge clk);
      reset     = 1'b1;
      corr_seen = 0;
   endtask

   // flips: one nibble per codeword (same layout as w); nonzero = position to invert.
   task automatic send_word(input logic [23:0] w, input logic [23:0] flips, input bit sync,
                            input bit gap, input bit watch, input string name);
      logic [6:0] code;
      int p;
      if (watch) idle_bad = 0;
      for (int k = 0; k < 6; k++) begin
         code = enc(w[23-4*k -: 4]);
         p    = int'(flips[23-4*k -: 4]);
         if (p != 0) code = code ^ (7'b1000000 >> (p - 1));
         for (int b = 0; b < 7; b++) begin
            if (gap && !(k == 0 && b == 0)) drive(1'b0, 1'b0, 1'b0, watch);
            drive(code[6-b], 1'b1, sync && (k == 0) && (b == 0), watch);
         end
      end
      if (watch) begin
         n_cmp++;
         if (idle_bad != 0) begin
            n_bad++;
            $display("FAIL %s idle: unbuf_en low on %0d collect cycles, expected 0", name, idle_bad);
         end
      end
   endtask

   // Called right after the last bit is driven; checks cycles N+1..N+7 and the word.
   task automatic check_burst(input logic [23:0] exp, input bit stop, input string name);
      logic [23:0] got;
      logic [3:0]  exp_nib;
      got = '0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         exp_nib = exp[23-4*(c-1) -: 4];
         if (corr_flag === 1'b1) corr_seen++;
         n_cmp++;
         if (unbuf_en !== 1'b0 || nibble_out !== exp_nib) begin
            n_bad++;
            $display("FAIL %s burst cyc %0d: unbuf_en=%b nibble=%h, expected unbuf_en=0 nibble=%h",
                     name, c, unbuf_en, nibble_out, exp_nib);
         end
         got = {got[19:0], nibble_out};
         if (stop && c == 1) begin
            bit_valid = 1'b0;
            sync_in   = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (unbuf_en !== 1'b1 || nibble_out !== exp[3:0]) begin
         n_bad++;
         $display("FAIL %s burst end: unbuf_en=%b nibble=%h, expected unbuf_en=1 nibble=%h",
                  name, unbuf_en, nibble_out, exp[3:0]);
      end
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s word: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle_window(input int n, input logic [3:0] exp_nib, input string name);
      int bad;
      bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (unbuf_en !== 1'b1 || nibble_out !== exp_nib) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL %s hold: %0d bad idle cycles (unbuf_en=%b nibble=%h), expected 0 (unbuf_en=1 nibble=%h)",
                  name, bad, unbuf_en, nibble_out, exp_nib);
      end
   endtask

   task automatic check_corr(input int exp_corr, input logic [1:0] exp_err, input string name);
      n_cmp++;
      if (corr_seen != exp_corr) begin
         n_bad++;
         $display("FAIL %s corr_flag: %0d pulses, expected %0d", name, corr_seen, exp_corr);
      end
      n_cmp++;
      if (err_count !== exp_err) begin
         n_bad++;
         $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err);
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (nibble_out !== 4'h0 || unbuf_en !== 1'b1 || corr_flag !== 1'b0 || err_count !== 2'd0) begin
         n_bad++;
         $display("FAIL reset: nibble=%h unbuf_en=%b corr=%b err=%0d, expected 0 1 0 0",
                  nibble_out, unbuf_en, corr_flag, err_count);
      end
      @(negedge clk);
      reset = 1'b1;
      idle_window(4, 4'h0, "reset");
   endtask

   task automatic test_clean();
      do_reset();
      send_word(24'h0F0F0F, 24'h0, 1'b1, 1'b0, 1'b1, "clean");
      check_burst(24'h0F0F0F, 1'b1, "clean");
      check_corr(0, 2'd0, "clean");
      idle_window(8, 4'hF, "clean");
   endtask

   task automatic test_single_error();
      do_reset();
      send_word(24'hFFFFFF, 24'h003000, 1'b1, 1'b0, 1'b1, "single_err");
      check_burst(24'hFFFFFF, 1'b1, "single_err");
      check_corr(1, CNT_EN ? 2'd1 : 2'd0, "single_err");
   endtask

   task automatic test_gapped();
      do_reset();
      send_word(24'hA5A5A5, 24'h0, 1'b1, 1'b1, 1'b1, "gapped");
      check_burst(24'hA5A5A5, 1'b1, "gapped");
      check_corr(0, 2'd0, "gapped");
   endtask

   task automatic test_resync();
      logic [19:0] pat;
      do_reset();
      pat = 20'hB3D5A;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) drive(pat[19-i], 1'b1, i == 0, 1'b1);
      send_word(24'h3C96E1, 24'h0, 1'b1, 1'b0, 1'b1, "resync");
      check_burst(24'h3C96E1, 1'b1, "resync");
      idle_window(12, 4'h1, "resync");
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_word(24'h13579B, 24'h0, 1'b1, 1'b0, 1'b1, "b2b_first");
      fork
         send_word(24'h2468AC, 24'h0, 1'b0, 1'b0, 1'b0, "b2b_second");
         check_burst(24'h13579B, 1'b0, "b2b_first");
      join
      check_burst(24'h2468AC, 1'b1, "b2b_second");
      idle_window(6, 4'hC, "b2b");
   endtask

   task automatic test_saturation();
      do_reset();
      send_word(24'h5A3C96, 24'h172560, 1'b1, 1'b0, 1'b1, "saturate");
      check_burst(24'h5A3C96, 1'b1, "saturate");
      check_corr(5, CNT_EN ? 2'd3 : 2'd0, "saturate");
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      send_word(24'h9ABCDE, 24'h0, 1'b1, 1'b0, 1'b1, "mid_reset");
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) bit_valid = 1'b0;
      end
      n_cmp++;
      if (unbuf_en !== 1'b0 || nibble_out !== 4'hB) begin
         n_bad++;
         $display("FAIL mid_reset pre: unbuf_en=%b nibble=%h, expected 0 b", unbuf_en, nibble_out);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (unbuf_en !== 1'b1 || nibble_out !== 4'h0 || corr_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset async: unbuf_en=%b nibble=%h corr=%b, expected 1 0 0",
                  unbuf_en, nibble_out, corr_flag);
      end
      @(negedge clk);
      reset = 1'b1;
      idle_window(10, 4'h0, "mid_reset");
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_error();
      test_gapped();
      test_resync();
      test_back_to_back();
      test_saturation();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
